// File: rtl/fifo_cfg_pkg.sv
// Shared configuration for the parametrised FIFO: default geometry, pointer
// width helper and the status flag bundle used by RTL and bench alike.
package fifo_cfg_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 16;
   localparam int unsigned DEF_DEPTH      = 8;

   function automatic int unsigned ptr_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   typedef struct packed {
      logic full;
      logic empty;
      logic almostfull;
      logic almostempty;
   } fifo_status_t;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH storage array: one synchronous write port, one
// combinational read port. Contents are intentionally not reset.
module fifo_mem
   import fifo_cfg_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned DEPTH      = DEF_DEPTH,
   localparam int unsigned AW        = ptr_w(DEPTH)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [AW-1:0]         raddr,
   output logic [DATA_WIDTH-1:0] rd_data_c
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   assign rd_data_c = mem_q[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with programmable almost-full/almost-empty
// levels, occupancy count, optional first-word-fall-through and flush.
module param_sync_fifo
   import fifo_cfg_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned DEPTH      = DEF_DEPTH,
   parameter int unsigned AFULL_LVL  = DEPTH - 1,
   parameter int unsigned AEMPTY_LVL = 1,
   parameter int unsigned FWFT       = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush,
   input  logic                    wr_en,
   input  logic [DATA_WIDTH-1:0]   data_in,
   input  logic                    rd_en,
   output logic [DATA_WIDTH-1:0]   data_out,
   output logic                    full,
   output logic                    empty,
   output logic                    almostfull,
   output logic                    almostempty,
   output logic                    wr_ack,
   output logic                    overflow,
   output logic                    underflow,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int unsigned PTR_W = ptr_w(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   if (((DEPTH & (DEPTH - 1)) != 0) || (DEPTH < 4)) begin : g_bad_depth
      $error("param_sync_fifo: DEPTH must be a power of two and at least 4");
   end
   if (!((AEMPTY_LVL >= 1) && (AEMPTY_LVL < AFULL_LVL) && (AFULL_LVL <= DEPTH - 1)))
   begin : g_bad_levels
      $error("param_sync_fifo: need 1 <= AEMPTY_LVL < AFULL_LVL <= DEPTH-1");
   end

   localparam fifo_status_t STATUS_RST = '{full: 1'b0, empty: 1'b1,
                                           almostfull: 1'b0, almostempty: 1'b0};

   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   fifo_status_t          status_q, status_d;
   logic                  wr_ack_q, wr_ack_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;
   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

   logic                  wr_acc_c;
   logic                  rd_acc_c;
   logic                  mem_we_c;
   logic [DATA_WIDTH-1:0] rd_data_c;

   function automatic fifo_status_t decode_status(input logic [CNT_W-1:0] c);
      fifo_status_t s;
      s.full        = (c == CNT_W'(DEPTH));
      s.empty       = (c == '0);
      s.almostfull  = (c >= CNT_W'(AFULL_LVL)) && !s.full;
      s.almostempty = !s.empty && (c <= CNT_W'(AEMPTY_LVL));
      return s;
   endfunction

   // Acceptance is judged on the flags as they stood before this edge
   assign wr_acc_c = wr_en && !status_q.full;
   assign rd_acc_c = rd_en && !status_q.empty;

   fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_mem (
      .clk       (clk),
      .we        (mem_we_c),
      .waddr     (wr_ptr_q),
      .wdata     (data_in),
      .raddr     (rd_ptr_q),
      .rd_data_c (rd_data_c)
   );

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      wr_ack_d    = 1'b0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      data_out_d  = data_out_q;
      mem_we_c    = 1'b0;

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         mem_we_c    = wr_acc_c;
         wr_ack_d    = wr_acc_c;
         overflow_d  = wr_en && !wr_acc_c;
         underflow_d = rd_en && !rd_acc_c;
         if (wr_acc_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (rd_acc_c) begin
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            data_out_d = rd_data_c;
         end
         unique case ({wr_acc_c, rd_acc_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end

      status_d = decode_status(count_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         status_q    <= STATUS_RST;
         wr_ack_q    <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         data_out_q  <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         status_q    <= status_d;
         wr_ack_q    <= wr_ack_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
         data_out_q  <= data_out_d;
      end
   end

   // FWFT exposes the head entry directly; standard mode uses the read register
   assign data_out    = (FWFT != 0) ? rd_data_c : data_out_q;
   assign full        = status_q.full;
   assign empty       = status_q.empty;
   assign almostfull  = status_q.almostfull;
   assign almostempty = status_q.almostempty;
   assign wr_ack      = wr_ack_q;
   assign overflow    = overflow_q;
   assign underflow   = underflow_q;
   assign count       = count_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench for param_sync_fifo: a queue scoreboard predicts data,
// count, flags and handshakes for a standard instance; a second instance runs FWFT.
module tb_param_sync_fifo;
   import fifo_cfg_pkg::*;

   localparam int unsigned DW    = 16;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned CW    = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic          s_flush = 1'b0, s_wr_en = 1'b0, s_rd_en = 1'b0;
   logic [DW-1:0] s_data_in = '0, s_data_out;
   logic          s_full, s_empty, s_af, s_ae, s_wr_ack, s_ovf, s_udf;
   logic [CW-1:0] s_count;

   logic          f_flush = 1'b0, f_wr_en = 1'b0, f_rd_en = 1'b0;
   logic [DW-1:0] f_data_in = '0, f_data_out;
   logic          f_full, f_empty, f_af, f_ae, f_wr_ack, f_ovf, f_udf;
   logic [CW-1:0] f_count;

   int errors = 0;
   int checks = 0;
   logic [DW-1:0] sb[$];
   int            mcount = 0;
   logic [DW-1:0] last_data = '0;

   always #5 clk = ~clk;

   param_sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0)) u_std (
      .clk(clk), .rst_n(rst_n), .flush(s_flush), .wr_en(s_wr_en), .data_in(s_data_in),
      .rd_en(s_rd_en), .data_out(s_data_out), .full(s_full), .empty(s_empty),
      .almostfull(s_af), .almostempty(s_ae), .wr_ack(s_wr_ack), .overflow(s_ovf),
      .underflow(s_udf), .count(s_count)
   );

   param_sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1)) u_fwft (
      .clk(clk), .rst_n(rst_n), .flush(f_flush), .wr_en(f_wr_en), .data_in(f_data_in),
      .rd_en(f_rd_en), .data_out(f_data_out), .full(f_full), .empty(f_empty),
      .almostfull(f_af), .almostempty(f_ae), .wr_ack(f_wr_ack), .overflow(f_ovf),
      .underflow(f_udf), .count(f_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic fifo_status_t exp_status(input int c);
      fifo_status_t s;
      s.full        = (c == DEPTH);
      s.empty       = (c == 0);
      s.almostfull  = (c >= DEPTH - 1) && (c < DEPTH);
      s.almostempty = (c > 0) && (c <= 1);
      return s;
   endfunction

   task automatic check_std_state(input string tag);
      fifo_status_t st;
      st = '{full: s_full, empty: s_empty, almostfull: s_af, almostempty: s_ae};
      check({tag, " count"}, 32'(s_count), 32'(mcount));
      check({tag, " flags"}, 32'(st), 32'(exp_status(mcount)));
      check({tag, " data_out"}, 32'(s_data_out), 32'(last_data));
   endtask

   // One clock of the standard instance, predicted from the scoreboard
   task automatic do_op(input logic w, input logic [DW-1:0] d, input logic r, input string tag);
      logic wacc, racc;
      wacc = w && (mcount != DEPTH);
      racc = r && (mcount != 0);
      s_wr_en = w; s_data_in = d; s_rd_en = r;
      @(posedge clk); #1;
      s_wr_en = 1'b0; s_rd_en = 1'b0;
      if (racc) begin
         last_data = sb.pop_front();
         mcount--;
      end
      if (wacc) begin
         sb.push_back(d);
         mcount++;
      end
      check({tag, " wr_ack"}, 32'(s_wr_ack), 32'(wacc));
      check({tag, " overflow"}, 32'(s_ovf), 32'(w && !wacc));
      check({tag, " underflow"}, 32'(s_udf), 32'(r && !racc));
      check_std_state(tag);
   endtask

   initial begin
      #12;
      check_std_state("reset");
      check("reset hs", {29'd0, s_wr_ack, s_ovf, s_udf}, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 1; i <= 8; i++) do_op(1'b1, DW'(i), 1'b0, "fill");
      do_op(1'b1, 16'h0009, 1'b0, "wr_full");
      for (int i = 0; i < 8; i++) do_op(1'b0, '0, 1'b1, "drain");
      do_op(1'b0, '0, 1'b1, "rd_empty");

      do_op(1'b1, 16'h1111, 1'b1, "rw_empty");
      for (int i = 0; i < 3; i++) do_op(1'b1, DW'(16'h2000 + i), 1'b0, "to4");
      do_op(1'b1, 16'h3333, 1'b1, "rw_mid");
      for (int i = 0; i < 4; i++) do_op(1'b1, DW'(16'h4000 + i), 1'b0, "to8");
      do_op(1'b1, 16'h5555, 1'b1, "rw_full");
      while (mcount > 0) do_op(1'b0, '0, 1'b1, "drain2");

      for (int b = 0; b < 20; b++) begin
         do_op(1'b1, 16'($urandom), 1'b0, "wrap_w");
         do_op(1'b1, 16'($urandom), 1'b0, "wrap_w");
         do_op(1'b0, '0, 1'b1, "wrap_r");
      end
      while (mcount > 0) do_op(1'b0, '0, 1'b1, "drain3");

      for (int i = 0; i < 5; i++) do_op(1'b1, DW'(16'h6000 + i), 1'b0, "to5");
      s_flush = 1'b1; s_wr_en = 1'b1; s_data_in = 16'h7777;
      @(posedge clk); #1;
      s_flush = 1'b0; s_wr_en = 1'b0;
      sb.delete(); mcount = 0;
      check("flush wr_ack", 32'(s_wr_ack), 32'd0);
      check_std_state("flush");
      do_op(1'b1, 16'h8888, 1'b0, "post_flush_w");
      do_op(1'b0, '0, 1'b1, "post_flush_r");

      f_wr_en = 1'b1; f_data_in = 16'hA5A5;
      @(posedge clk); #1;
      f_wr_en = 1'b0;
      check("fwft wr_ack", 32'(f_wr_ack), 32'd1);
      check("fwft empty", 32'(f_empty), 32'd0);
      check("fwft count", 32'(f_count), 32'd1);
      check("fwft data", 32'(f_data_out), 32'hA5A5);
      @(posedge clk); #1;
      check("fwft hold", 32'(f_data_out), 32'hA5A5);
      f_rd_en = 1'b1;
      @(posedge clk); #1;
      f_rd_en = 1'b0;
      check("fwft pop empty", 32'(f_empty), 32'd1);
      check("fwft pop count", 32'(f_count), 32'd0);
      check("fwft pop flags", {28'd0, f_full, f_af, f_ae, f_udf}, 32'd0);
      check("fwft pop ovf", 32'(f_ovf), 32'd0);

      for (int i = 0; i < 7; i++) do_op(1'b1, DW'(16'h9000 + i), 1'b0, "burst");
      s_wr_en = 1'b1; s_data_in = 16'h9999;
      #2;
      rst_n = 1'b0;
      #1;
      sb.delete(); mcount = 0; last_data = '0;
      check_std_state("async_rst");
      check("async_rst hs", {29'd0, s_wr_ack, s_ovf, s_udf}, 32'd0);
      s_wr_en = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      do_op(1'b1, 16'hBEEF, 1'b0, "post_rst_w");
      do_op(1'b0, '0, 1'b1, "post_rst_r");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
